// File: rtl/videoctl_regbank.sv
// Video controller register bank: shadow registers committed atomically at vblank.
// Defining VIDEOCTL_READBACK_EN adds the registered CPU read-back path.
module videoctl_regbank #(
  parameter int PAL_BITS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                reg_clk,
  input  logic                nreset,
  input  logic                reg_wr,
  input  logic [5:0]          reg_addr,
  input  logic [7:0]          reg_data,
  input  logic                reg_rd,
  output logic [7:0]          reg_rdata,
  input  logic                vsync_in,
  output logic [15:0]         base_addr,
  output logic [9:0]          vp_left,
  output logic [9:0]          vp_right,
  output logic [9:0]          vp_top,
  output logic [9:0]          vp_bottom,
  output logic [5:0]          mode,
  input  logic [PAL_BITS-1:0] pal_idx,
  output logic [11:0]         pal_rgb,
  output logic                irq
);

  localparam int PAL_N = 1 << PAL_BITS;

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   do_copy;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   vs_d;
  logic                   vs;
  logic                   vbl_edge;

  logic [15:0] base_sh;
  logic [9:0]  left_sh;
  logic [9:0]  right_sh;
  logic [9:0]  top_sh;
  logic [9:0]  bottom_sh;
  logic [5:0]  mode_sh;
  logic        irq_en;
  logic        vbl_pend;

  logic [PAL_BITS-1:0] pal_index;
  logic [3:0]          pal_hi;
  logic [11:0]         pal_sh  [PAL_N];
  logic [11:0]         pal_act [PAL_N];

  logic commit_wr;
  logic clear_wr;
  logic pal_wr;

  assign commit_wr = reg_wr && (reg_addr == 6'h0B) && reg_data[0];
  assign clear_wr  = reg_wr && (reg_addr == 6'h0C) && reg_data[0];
  assign pal_wr    = nreset && reg_wr && (reg_addr == 6'h0F);

  // vld_q tracks which sync stages hold post-reset samples, so a
  // vsync already low at reset release cannot look like a falling edge.
  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      sync_q <= '1;
      vld_q  <= '0;
      vs_d   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], vsync_in};
      vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      vs_d   <= vs & vld_q[SYNC_STAGES-1];
    end
  end

  assign vs       = sync_q[SYNC_STAGES-1];
  assign vbl_edge = vs_d & ~vs;

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    do_copy = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_wr) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (vbl_edge) begin
          state_d = IDLE;
          do_copy = nreset;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      base_sh   <= '0;
      left_sh   <= '0;
      right_sh  <= '0;
      top_sh    <= '0;
      bottom_sh <= '0;
      mode_sh   <= '0;
      irq_en    <= 1'b0;
      pal_index <= '0;
      pal_hi    <= '0;
    end else if (reg_wr) begin
      case (reg_addr)
        6'h00: base_sh[15:8]  <= reg_data;
        6'h01: base_sh[7:0]   <= reg_data;
        6'h02: left_sh[9:8]   <= reg_data[1:0];
        6'h03: left_sh[7:0]   <= reg_data;
        6'h04: right_sh[9:8]  <= reg_data[1:0];
        6'h05: right_sh[7:0]  <= reg_data;
        6'h06: top_sh[9:8]    <= reg_data[1:0];
        6'h07: top_sh[7:0]    <= reg_data;
        6'h08: bottom_sh[9:8] <= reg_data[1:0];
        6'h09: bottom_sh[7:0] <= reg_data;
        6'h0A: mode_sh        <= reg_data[5:0];
        6'h0B: irq_en         <= reg_data[1];
        6'h0D: pal_index      <= reg_data[PAL_BITS-1:0];
        6'h0E: pal_hi         <= reg_data[3:0];
        6'h0F: pal_index      <= pal_index + 1'b1;
        default: ;
      endcase
    end
  end

  // A new vblank outranks a simultaneous W1C so no event is lost.
  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      vbl_pend <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (vbl_edge) begin
        vbl_pend <= 1'b1;
      end else if (clear_wr) begin
        vbl_pend <= 1'b0;
      end
      irq <= vbl_pend & irq_en;
    end
  end

  always_ff @(posedge reg_clk) begin
    if (pal_wr) begin
      pal_sh[pal_index] <= {pal_hi, reg_data};
    end
  end

  always_ff @(posedge reg_clk) begin
    if (do_copy) begin
      pal_act <= pal_sh;
    end
  end

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      base_addr <= '0;
      vp_left   <= '0;
      vp_right  <= '0;
      vp_top    <= '0;
      vp_bottom <= '0;
      mode      <= '0;
    end else if (do_copy) begin
      base_addr <= base_sh;
      vp_left   <= left_sh;
      vp_right  <= right_sh;
      vp_top    <= top_sh;
      vp_bottom <= bottom_sh;
      mode      <= mode_sh;
    end
  end

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      pal_rgb <= '0;
    end else begin
      pal_rgb <= pal_act[pal_idx];
    end
  end

`ifdef VIDEOCTL_READBACK_EN
  logic [7:0]  rd_val;
  logic [11:0] pal_cur;

  assign pal_cur = pal_sh[pal_index];

  always_comb begin
    rd_val = '0;
    case (reg_addr)
      6'h00: rd_val = base_sh[15:8];
      6'h01: rd_val = base_sh[7:0];
      6'h02: rd_val = {6'd0, left_sh[9:8]};
      6'h03: rd_val = left_sh[7:0];
      6'h04: rd_val = {6'd0, right_sh[9:8]};
      6'h05: rd_val = right_sh[7:0];
      6'h06: rd_val = {6'd0, top_sh[9:8]};
      6'h07: rd_val = top_sh[7:0];
      6'h08: rd_val = {6'd0, bottom_sh[9:8]};
      6'h09: rd_val = bottom_sh[7:0];
      6'h0A: rd_val = {2'd0, mode_sh};
      6'h0B: rd_val = {6'd0, irq_en, 1'b0};
      6'h0C: rd_val = {6'd0, state_q == PENDING, vbl_pend};
      6'h0D: rd_val[PAL_BITS-1:0] = pal_index;
      6'h0E: rd_val = {pal_hi, pal_cur[11:8]};
      6'h0F: rd_val = pal_cur[7:0];
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge reg_clk) begin
    if (!nreset) begin
      reg_rdata <= '0;
    end else if (reg_rd) begin
      reg_rdata <= rd_val;
    end
  end
`else
  logic unused_rd;

  assign unused_rd = reg_rd;
  assign reg_rdata = '0;
`endif

endmodule

// File: tb/tb_videoctl_regbank.sv
// Directed bench for videoctl_regbank: register map, commit timing,
// palette, irq and reset corner cases.
module tb_videoctl_regbank;

  localparam int PAL_BITS    = 4;
  localparam int SYNC_STAGES = 2;

  logic                reg_clk;
  logic                nreset;
  logic                reg_wr;
  logic [5:0]          reg_addr;
  logic [7:0]          reg_data;
  logic                reg_rd;
  logic [7:0]          reg_rdata;
  logic                vsync_in;
  logic [15:0]         base_addr;
  logic [9:0]          vp_left;
  logic [9:0]          vp_right;
  logic [9:0]          vp_top;
  logic [9:0]          vp_bottom;
  logic [5:0]          mode;
  logic [PAL_BITS-1:0] pal_idx;
  logic [11:0]         pal_rgb;
  logic                irq;

  int checks;
  int failures;

  videoctl_regbank #(
    .PAL_BITS    (PAL_BITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .reg_clk   (reg_clk),
    .nreset    (nreset),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .vsync_in  (vsync_in),
    .base_addr (base_addr),
    .vp_left   (vp_left),
    .vp_right  (vp_right),
    .vp_top    (vp_top),
    .vp_bottom (vp_bottom),
    .mode      (mode),
    .pal_idx   (pal_idx),
    .pal_rgb   (pal_rgb),
    .irq       (irq)
  );

  initial reg_clk = 1'b0;
  always #5 reg_clk = ~reg_clk;

  typedef struct {
    logic [5:0]  addr;
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          sel;
    logic [15:0] exp;
  } rvec_t;

  typedef struct {
    logic [PAL_BITS-1:0] idx;
    logic [11:0]         exp;
  } pvec_t;

  rvec_t rtab[6];
  pvec_t ptab[3];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge reg_clk);
    reg_wr   = 1'b1;
    reg_addr = a;
    reg_data = d;
    @(posedge reg_clk);
    #1;
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a);
    @(negedge reg_clk);
    reg_rd   = 1'b1;
    reg_addr = a;
    @(posedge reg_clk);
    #1;
    reg_rd = 1'b0;
    @(negedge reg_clk);
  endtask

  task automatic vs_pulse();
    @(negedge reg_clk);
    vsync_in = 1'b0;
    repeat (10) @(negedge reg_clk);
    vsync_in = 1'b1;
    repeat (SYNC_STAGES + 4) @(negedge reg_clk);
  endtask

  task automatic pal_chk(input string name, input logic [PAL_BITS-1:0] i,
                         input logic [11:0] e);
    @(negedge reg_clk);
    pal_idx = i;
    @(negedge reg_clk);
    check(name, 32'(pal_rgb), 32'(e));
  endtask

  function automatic logic [31:0] sel_out(input int s);
    case (s)
      0:       return 32'(base_addr);
      1:       return 32'(vp_left);
      2:       return 32'(vp_right);
      3:       return 32'(vp_top);
      default: return 32'(vp_bottom);
    endcase
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    nreset   = 1'b0;
    reg_wr   = 1'b0;
    reg_rd   = 1'b0;
    reg_addr = '0;
    reg_data = '0;
    vsync_in = 1'b1;
    pal_idx  = '0;

    rtab[0] = '{6'h00, 8'hAB, 8'hCD, 0, 16'hABCD};
    rtab[1] = '{6'h20, 8'hFF, 8'hFF, 0, 16'hABCD};
    rtab[2] = '{6'h02, 8'hFF, 8'hFF, 1, 16'h03FF};
    rtab[3] = '{6'h04, 8'h02, 8'h10, 2, 16'h0210};
    rtab[4] = '{6'h06, 8'hFD, 8'h01, 3, 16'h0101};
    rtab[5] = '{6'h08, 8'h01, 8'h80, 4, 16'h0180};
    ptab[0] = '{4'd15, 12'hABC};
    ptab[1] = '{4'd0,  12'h123};
    ptab[2] = '{4'd1,  12'h456};

    repeat (3) @(negedge reg_clk);
    check("rst_base", 32'(base_addr), 'h0);
    check("rst_left", 32'(vp_left), 'h0);
    check("rst_mode", 32'(mode), 'h0);
    check("rst_pal_rgb", 32'(pal_rgb), 'h0);
    check("rst_irq", 32'(irq), 'h0);
    check("rst_rdata", 32'(reg_rdata), 'h0);
    nreset = 1'b1;
    repeat (SYNC_STAGES + 3) @(negedge reg_clk);

    // Shadow writes without commit never reach the outputs.
    wr(6'h00, 8'h12);
    wr(6'h01, 8'h34);
    wr(6'h0A, 8'h05);
    vs_pulse();
    check("nocommit_base", 32'(base_addr), 'h0);
    check("nocommit_mode", 32'(mode), 'h0);
    check("nocommit_irq", 32'(irq), 'h0);
    wr(6'h0B, 8'h02);
    repeat (2) @(negedge reg_clk);
    check("vblpend_irq", 32'(irq), 'h1);
    wr(6'h0C, 8'h01);
    repeat (2) @(negedge reg_clk);
    check("w1c_irq", 32'(irq), 'h0);

    // Commit latency and irq lag.
    wr(6'h00, 8'h12);
    wr(6'h01, 8'h34);
    wr(6'h0B, 8'h03);
    @(negedge reg_clk);
    vsync_in = 1'b0;
    for (int k = 1; k <= SYNC_STAGES; k++) begin
      @(negedge reg_clk);
      check("lat_early", 32'(base_addr), 'h0);
    end
    @(negedge reg_clk);
    check("lat_base", 32'(base_addr), 'h1234);
    check("lat_mode", 32'(mode), 'h05);
    check("irq_lag0", 32'(irq), 'h0);
    @(negedge reg_clk);
    check("irq_lag1", 32'(irq), 'h1);
    wr(6'h0C, 8'h01);
    repeat (2) @(negedge reg_clk);
    check("irq_clr", 32'(irq), 'h0);
    repeat (6) @(negedge reg_clk);
    check("one_pulse_irq", 32'(irq), 'h0);
    vsync_in = 1'b1;
    repeat (SYNC_STAGES + 4) @(negedge reg_clk);

    // Palette with index wrap.
    wr(6'h0D, 8'h0F);
    wr(6'h0E, 8'h0A);
    wr(6'h0F, 8'hBC);
    wr(6'h0E, 8'h01);
    wr(6'h0F, 8'h23);
    wr(6'h0E, 8'h04);
    wr(6'h0F, 8'h56);
    wr(6'h0B, 8'h01);
    vs_pulse();
    for (int i = 0; i < 3; i++) begin
      pal_chk($sformatf("pal_%0d", ptab[i].idx), ptab[i].idx, ptab[i].exp);
    end

    // pal_rgb shows the old palette during the commit cycle.
    @(negedge reg_clk);
    pal_idx = 4'd1;
    wr(6'h0D, 8'h01);
    wr(6'h0E, 8'h07);
    wr(6'h0F, 8'h89);
    wr(6'h0B, 8'h01);
    @(negedge reg_clk);
    vsync_in = 1'b0;
    repeat (SYNC_STAGES + 1) @(negedge reg_clk);
    check("pal_commit_old", 32'(pal_rgb), 'h456);
    @(negedge reg_clk);
    check("pal_commit_new", 32'(pal_rgb), 'h789);
    repeat (4) @(negedge reg_clk);
    vsync_in = 1'b1;
    repeat (SYNC_STAGES + 4) @(negedge reg_clk);

    // Register map table, including masked hi bytes and ignored addresses.
    for (int i = 0; i < 6; i++) begin
      wr(rtab[i].addr, rtab[i].hi);
      wr(rtab[i].addr + 6'd1, rtab[i].lo);
      wr(6'h0B, 8'h01);
      vs_pulse();
      check($sformatf("regmap_%0h", rtab[i].addr), sel_out(rtab[i].sel),
            32'(rtab[i].exp));
    end
    wr(6'h0A, 8'hC7);
    wr(6'h0B, 8'h01);
    vs_pulse();
    check("mode_mask", 32'(mode), 'h07);

    // COMMIT landing on the vbl_edge cycle defers the copy.
    wr(6'h00, 8'h43);
    wr(6'h01, 8'h21);
    @(negedge reg_clk);
    vsync_in = 1'b0;
    repeat (SYNC_STAGES) @(negedge reg_clk);
    reg_wr   = 1'b1;
    reg_addr = 6'h0B;
    reg_data = 8'h01;
    @(posedge reg_clk);
    #1;
    reg_wr = 1'b0;
    repeat (6) @(negedge reg_clk);
    check("coinc_nocopy", 32'(base_addr), 'hABCD);
    vsync_in = 1'b1;
    repeat (SYNC_STAGES + 4) @(negedge reg_clk);
    vsync_in = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge reg_clk);
    check("coinc_next", 32'(base_addr), 'h4321);
    vsync_in = 1'b1;
    repeat (SYNC_STAGES + 4) @(negedge reg_clk);

`ifdef VIDEOCTL_READBACK_EN
    wr(6'h02, 8'h01);
    wr(6'h03, 8'h2C);
    rd(6'h02);
    check("rb_left_hi", 32'(reg_rdata), 'h01);
    rd(6'h03);
    check("rb_left_lo", 32'(reg_rdata), 'h2C);
    wr(6'h0A, 8'h3F);
    rd(6'h0A);
    check("rb_mode", 32'(reg_rdata), 'h3F);
    rd(6'h20);
    check("rb_unused", 32'(reg_rdata), 'h00);
    wr(6'h0C, 8'h01);
    wr(6'h0B, 8'h01);
    rd(6'h0C);
    check("rb_status_pend", 32'(reg_rdata), 'h02);
    vs_pulse();
    rd(6'h0C);
    check("rb_status_done", 32'(reg_rdata), 'h01);
`else
    rd(6'h02);
    check("rd_off_02", 32'(reg_rdata), 'h00);
    rd(6'h0A);
    check("rd_off_0a", 32'(reg_rdata), 'h00);
`endif

    // Reset while PENDING with vsync held low.
    wr(6'h00, 8'h55);
    wr(6'h01, 8'h55);
    wr(6'h0B, 8'h01);
    @(negedge reg_clk);
    nreset   = 1'b0;
    vsync_in = 1'b0;
    repeat (3) @(negedge reg_clk);
    nreset = 1'b1;
    repeat (8) @(negedge reg_clk);
    check("rstp_base", 32'(base_addr), 'h0);
    check("rstp_left", 32'(vp_left), 'h0);
    check("rstp_bottom", 32'(vp_bottom), 'h0);
    check("rstp_mode", 32'(mode), 'h0);
    check("rstp_irq", 32'(irq), 'h0);
    wr(6'h0B, 8'h02);
    repeat (2) @(negedge reg_clk);
    check("rstp_no_edge", 32'(irq), 'h0);
    vsync_in = 1'b1;
    repeat (SYNC_STAGES + 4) @(negedge reg_clk);
    vsync_in = 1'b0;
    repeat (SYNC_STAGES + 3) @(negedge reg_clk);
    check("rstp_edge_irq", 32'(irq), 'h1);
    check("rstp_edge_base", 32'(base_addr), 'h0);
    vsync_in = 1'b1;
    repeat (4) @(negedge reg_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/videoctl_regbank.md
Name: videoctl_regbank

Overview:
- Parametrised control-register bank for the video controller, clocked by reg_clk.
- Holds shadow copies of the viewport, base and mode registers and a palette of 2^PAL_BITS entries. Palette is written indirectly through an index/data port with auto-increment.
- On a CPU commit request, all shadow state is copied to the active outputs atomically at the next vblank edge, so mid-frame register writes never tear. Also raises a vblank interrupt.

Parameters:
- PAL_BITS, 4, log2 of palette entries; legal range 1..8.
- SYNC_STAGES, 2, synchroniser depth for vsync_in; minimum 2.

Ports:
- reg_clk  input  1  register/CPU clock
- nreset  input  1  reset, synchronous, active-low
- reg_wr  input  1  write strobe, one byte per cycle
- reg_addr  input  6  byte address
- reg_data  input  8  write data
- reg_rd  input  1  read strobe (optional feature)
- reg_rdata  output  8  read data (optional feature)
- vsync_in  input  1  active-low vsync from the pixel domain, asynchronous
- base_addr  output  16  active video base address
- vp_left, vp_right, vp_top, vp_bottom  output  10 each  active viewport bounds
- mode  output  6  active mode byte [5:0]
- pal_idx  input  PAL_BITS  active-palette read index
- pal_rgb  output  12  active-palette entry R4G4B4, registered
- irq  output  1  vblank interrupt, level

Behaviour:
- Register map (byte addresses, hi byte at the even address):
  - 00/01 BASE
  - 02/03 LEFT, 04/05 RIGHT, 06/07 TOP, 08/09 BOTTOM; only bits [1:0] of each hi byte are stored.
  - 0A MODE [5:0]
  - 0B CTRL: bit0 = COMMIT (write 1 to request; self-clearing, not stored); bit1 = IRQ_EN.
  - 0C STATUS: bit0 = VBL_PEND (write 1 clears); bit1 = COMMIT_PEND (read-only).
  - 0D PAL_INDEX: only the low PAL_BITS bits are stored.
  - 0E PAL_HI: bits [3:0] are latched into a holding register.
  - 0F PAL_LO: a write stores {PAL_HI holding[3:0], data} into shadow palette[PAL_INDEX], then PAL_INDEX increments modulo 2^PAL_BITS.
  - 10..3F: writes are ignored.
- Reset values:
  - All shadow and active registers, CTRL, STATUS, PAL_INDEX, PAL_HI holding, pal_rgb, irq and reg_rdata = 0.
  - Synchroniser flops = 1 (vsync inactive).
  - Palette memories are not reset; they are zero-initialised in simulation only.
- vblank edge detection:
  - vsync_in passes through SYNC_STAGES flops, then an edge detector.
  - vbl_edge is a one-cycle pulse on the synchronised 1->0 transition. Latency is SYNC_STAGES+1 reg_clk cycles from the vsync_in fall.
  - A low level held for any length produces exactly one pulse.
- Commit state machine, states IDLE and PENDING:
  - IDLE -> PENDING on a CTRL write with bit0 = 1.
  - PENDING -> IDLE on vbl_edge. In that same cycle, every active register and all 2^PAL_BITS active-palette entries take their shadow values. The copy is one cycle wide; the palette is implemented as a register array, or as a bank-select over two memories with a swap plus copy-back; either implementation must be observably atomic.
  - A COMMIT write and vbl_edge in the same cycle: no copy happens; the FSM enters PENDING and commits at the following edge.
  - A COMMIT write while already PENDING has no effect.
  - A shadow write in the same cycle as the copy: the copy uses the pre-write shadow value; the new value reaches the outputs at the next commit.
- Interrupt:
  - VBL_PEND sets on every vbl_edge, whether or not a commit occurs.
  - A set and a W1C in the same cycle: set wins.
  - irq = VBL_PEND & IRQ_EN, registered, so it lags VBL_PEND by 1 cycle.
- Palette read port:
  - pal_rgb <= active_palette[pal_idx] every cycle; 1-cycle latency.
  - In the commit cycle, pal_rgb still reflects the old active palette; the new values appear on the next cycle.
- Reset mid-operation: PENDING is abandoned, nothing is copied, and the synchroniser is re-primed to 1. A vsync_in already low at reset release does not generate an edge.

Optional Feature:
- Macro: VIDEOCTL_READBACK_EN.
- With the macro defined:
  - reg_rdata <= value at reg_addr, one cycle after reg_rd.
  - Readable values are the shadow registers, CTRL bit1, STATUS, PAL_INDEX, PAL_HI holding, and shadow palette[PAL_INDEX] split as 0E = hi nibble and 0F = low byte.
  - Reading 0F does not increment PAL_INDEX.
  - Unused addresses read 00.
- Without the macro: reg_rd is ignored and reg_rdata is constant 0; no read mux is synthesised.

Test Plan:
- Write BASE=12 34, MODE=05, no commit, pulse vsync_in low -> base_addr stays 0000 and mode stays 00; VBL_PEND=1; irq=0 (IRQ_EN=0).
- Write BASE=12 34, then CTRL=03, then vsync_in low for 10 cycles -> base_addr=1234 exactly SYNC_STAGES+1 cycles after the fall; COMMIT_PEND returns to 0; irq=1 one cycle after VBL_PEND; writing STATUS=01 clears irq.
- PAL_BITS=4: PAL_INDEX=0F, PAL_HI=0A, PAL_LO=BC, PAL_HI=01, PAL_LO=23, then commit -> palette[15]=ABC, palette[0]=123 (index wrapped), PAL_INDEX=01; pal_idx=0 gives pal_rgb=123 one cycle later.
- COMMIT write coincident with vbl_edge -> no copy at that edge; copy occurs at the next vsync fall.
- Assert nreset while PENDING, then release with vsync_in held low -> no edge, no copy, all outputs 0; the next real falling edge sets VBL_PEND only.
- VIDEOCTL_READBACK_EN: write VP_LEFT=01 2C, read 02/03 -> 01 then 2C; read 0A after MODE=3F -> 3F; read 20 -> 00. Without the macro, reg_rdata stays 00.
